// File: rtl/omsp_clock_en_gen.sv
// omsp_clock_en_gen: NCH-channel clock-enable generator for the openMSP430
// clock module. Each channel divides mclk ticks or synchronised lfxt_clk
// edges by (DIV+1). An LFXT watchdog raises a sticky fault and forces LFXT
// channels onto mclk ticks while the fault is live.
module omsp_clock_en_gen #(
  parameter int unsigned NCH       = 2,
  parameter logic [7:0]  BASE_ADDR = 8'h60,
  parameter int unsigned TO_W      = 8,
  parameter int unsigned LFXT_TO   = 200
) (
  input  logic             mclk,
  input  logic             puc,
  input  logic             lfxt_clk,
  input  logic [NCH-1:0]   ch_stop,
  input  logic [7:0]       per_addr,
  input  logic [15:0]      per_din,
  input  logic             per_en,
  input  logic [1:0]       per_wen,
  output logic [15:0]      per_dout,
  output logic [NCH-1:0]   clk_en,
  output logic             lfxt_fault
);

  localparam logic [TO_W-1:0] WD_MAX    = TO_W'(LFXT_TO);
  localparam logic [7:0]      STAT_ADDR = BASE_ADDR + 8'(NCH);

  // Channel configuration and divider state
  logic [7:0]      div_q [NCH];
  logic [7:0]      cnt_q [NCH];
  logic [NCH-1:0]  sel_q;
  logic [NCH-1:0]  off_q;

  // LFXT synchroniser, watchdog and fault flags
  logic [2:0]      sync_q;
  logic [TO_W-1:0] wd_cnt;
  logic            fault_live;
  logic            fault_q;

  // Decoded control
  logic            lfxt_tick;
  logic            wr_any;
  logic            rd_any;
  logic            stat_sel;
  logic            fault_live_nxt;
  logic            fault_set;
  logic            fault_clr;
  logic [NCH-1:0]  ch_sel;
  logic [NCH-1:0]  ch_wr;
  logic [NCH-1:0]  src;
  logic [NCH-1:0]  active;

  // Reserved write-data bits are never stored
  logic            unused_din;
  assign unused_din = ^per_din[15:10];

  // Address decode, tick sources and fault edge detection
  always_comb begin
    lfxt_tick      = sync_q[1] & ~sync_q[2];
    wr_any         = per_en & (|per_wen);
    rd_any         = per_en & (per_wen == 2'b00);
    stat_sel       = (per_addr == STAT_ADDR);
    // A tick this cycle means the counter restarts, so the live flag drops at the same edge
    fault_live_nxt = ~lfxt_tick & (wd_cnt == WD_MAX);
    fault_set      = fault_live_nxt & ~fault_live;
    fault_clr      = wr_any & stat_sel & per_wen[0] & per_din[0];
    ch_sel         = '0;
    ch_wr          = '0;
    src            = '0;
    active         = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      ch_sel[k] = (per_addr == BASE_ADDR + 8'(k));
      ch_wr[k]  = wr_any & ch_sel[k];
      src[k]    = sel_q[k] ? (fault_live | lfxt_tick) : 1'b1;
      active[k] = ~off_q[k] & ~ch_stop[k];
    end
  end

  // Combinational read mux, zero when not selected
  always_comb begin
    per_dout = '0;
    if (rd_any) begin
      if (stat_sel) per_dout = {14'b0, fault_live, fault_q};
      for (int unsigned k = 0; k < NCH; k++) begin
        if (ch_sel[k]) per_dout = {6'b0, off_q[k], sel_q[k], div_q[k]};
      end
    end
  end

  // LFXT synchroniser, watchdog counter and sticky fault
  always_ff @(posedge mclk) begin
    if (puc) begin
      sync_q     <= '0;
      wd_cnt     <= '0;
      fault_live <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], lfxt_clk};
      if (lfxt_tick)             wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + TO_W'(1);
      fault_live <= fault_live_nxt;
      if (fault_set)      fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
    end
  end

  // Byte-writable channel configuration registers
  always_ff @(posedge mclk) begin
    if (puc) begin
      for (int unsigned k = 0; k < NCH; k++) div_q[k] <= '0;
      sel_q <= '0;
      off_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (ch_wr[k] & per_wen[0]) div_q[k] <= per_din[7:0];
        if (ch_wr[k] & per_wen[1]) begin
          sel_q[k] <= per_din[8];
          off_q[k] <= per_din[9];
        end
      end
    end
  end

  // Per-channel divider and registered enable pulse; a register write restarts the phase
  always_ff @(posedge mclk) begin
    if (puc) begin
      for (int unsigned k = 0; k < NCH; k++) cnt_q[k] <= '0;
      clk_en <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (ch_wr[k]) begin
          cnt_q[k]  <= '0;
          clk_en[k] <= 1'b0;
        end else begin
          if (src[k] & active[k])
            cnt_q[k] <= (cnt_q[k] == div_q[k]) ? 8'd0 : cnt_q[k] + 8'd1;
          clk_en[k] <= src[k] & active[k] & (cnt_q[k] == div_q[k]);
        end
      end
    end
  end

  assign lfxt_fault = fault_q;

endmodule
